// File: rtl/axi_adapter_arbiter.sv
// axi_adapter_arbiter: round-robin sharing of one single-outstanding AXI adapter among NR_PORTS requesters
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_i/type_i/we_i/addr_i/size_i/
//   id_i/wdata_i/be_i                 per-requester request fields (packed, port p at slice p)
//   gnt_o, valid_o,
//   critical_word_valid_o             one-hot handshakes routed to the owning requester
//   rdata_o, id_o, critical_word_o    adapter response, broadcast
//   err_o                             sticky error: watchdog expiry or completion seen while issuing
//   adp_*_o                           owner's request towards the adapter
//   adp_*_i                           adapter status, handshake and response
module axi_adapter_arbiter #(
    parameter int NR_PORTS   = 3,
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int XLEN       = 64,
    parameter int TIMEOUT    = 1023
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NR_PORTS-1:0]            req_i,
    input  logic [NR_PORTS-1:0]            type_i,
    input  logic [NR_PORTS-1:0]            we_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NR_PORTS*2-1:0]          size_i,
    input  logic [NR_PORTS*ID_WIDTH-1:0]   id_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
    output logic [NR_PORTS-1:0]            gnt_o,
    output logic [NR_PORTS-1:0]            valid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [ID_WIDTH-1:0]            id_o,
    output logic [XLEN-1:0]                critical_word_o,
    output logic [NR_PORTS-1:0]            critical_word_valid_o,
    output logic                           err_o,
    output logic                           adp_req_o,
    output logic                           adp_type_o,
    output logic                           adp_we_o,
    output logic [ADDR_WIDTH-1:0]          adp_addr_o,
    output logic [1:0]                     adp_size_o,
    output logic [ID_WIDTH-1:0]            adp_id_o,
    output logic [DATA_WIDTH-1:0]          adp_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        adp_be_o,
    input  logic                           adp_busy_i,
    input  logic                           adp_gnt_i,
    input  logic                           adp_valid_i,
    input  logic [DATA_WIDTH-1:0]          adp_rdata_i,
    input  logic [ID_WIDTH-1:0]            adp_id_i,
    input  logic [XLEN-1:0]                adp_cw_i,
    input  logic                           adp_cw_valid_i
);
    localparam int OW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;
    localparam logic [NR_PORTS-1:0] ONE = NR_PORTS'(1);

    logic [1:0]          state_q;
    logic [OW-1:0]       owner_q, rr_ptr_q, winner, rr_next;
    logic [WW-1:0]       wd_cnt_q;
    logic                err_q;
    logic                issue, waiting;
    logic [NR_PORTS-1:0] owner_hot;

    // Scan downward so the closest requester at or after rr_ptr_q is written last and wins.
    always_comb begin
        winner = rr_ptr_q;
        for (int k = NR_PORTS - 1; k >= 0; k--)
            if (req_i[(int'(rr_ptr_q) + k) % NR_PORTS]) winner = OW'((int'(rr_ptr_q) + k) % NR_PORTS);
    end

    assign rr_next   = (owner_q == OW'(NR_PORTS - 1)) ? '0 : owner_q + 1'b1;
    // Handshake outputs are masked during reset because the state register only clears at the edge.
    assign issue     = !rst_i && state_q == ISSUE;
    assign waiting   = !rst_i && state_q == WAIT_RESP;
    assign owner_hot = ONE << owner_q;

    assign adp_req_o             = issue;
    assign gnt_o                 = (issue && adp_gnt_i) ? owner_hot : '0;
    assign valid_o               = (waiting && adp_valid_i) ? owner_hot : '0;
    assign critical_word_valid_o = (waiting && adp_cw_valid_i) ? owner_hot : '0;
    assign rdata_o               = adp_rdata_i;
    assign id_o                  = adp_id_i;
    assign critical_word_o       = adp_cw_i;
    assign err_o                 = err_q && !rst_i;

    // The owner mux stays up through WAIT_RESP since the adapter keeps reading the fields.
    assign adp_type_o  = type_i[owner_q];
    assign adp_we_o    = we_i[owner_q];
    assign adp_addr_o  = addr_i[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign adp_size_o  = size_i[owner_q*2 +: 2];
    assign adp_id_o    = id_i[owner_q*ID_WIDTH +: ID_WIDTH];
    assign adp_wdata_o = wdata_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign adp_be_o    = be_i[owner_q*BW +: BW];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|req_i) begin
                    owner_q <= winner;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    // A completion while issuing breaks the adapter protocol: drop it, flag it.
                    if (adp_valid_i) err_q <= 1'b1;
                    if (adp_gnt_i) begin
                        state_q  <= WAIT_RESP;
                        wd_cnt_q <= '0;
                    end else if (!req_i[owner_q] && !adp_busy_i) state_q <= IDLE;
                end
                WAIT_RESP: begin
                    wd_cnt_q <= (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + 1'b1;
                    if (TIMEOUT != 0 && wd_cnt_q == WW'(TIMEOUT)) err_q <= 1'b1;
                    if (adp_valid_i) begin
                        rr_ptr_q <= rr_next;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// tb_axi_adapter_arbiter: scoreboard-driven bench for axi_adapter_arbiter with a scripted adapter
module tb_axi_adapter_arbiter;
    localparam int NP = 3;
    localparam int DW = 256;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int XL = 64;

    typedef struct {
        int             port;
        logic [DW-1:0]  rdata;
    } exp_t;

    logic             clk_i = 0, rst_i = 1;
    logic [NP-1:0]    req_i = 0, type_i = 0, we_i = 0;
    logic [NP*AW-1:0] addr_i;
    logic [NP*2-1:0]  size_i = 0;
    logic [NP*IW-1:0] id_i = 0;
    logic [NP*DW-1:0] wdata_i = 0;
    logic [NP*DW/8-1:0] be_i = 0;
    logic [NP-1:0]    gnt_o, valid_o, critical_word_valid_o;
    logic [DW-1:0]    rdata_o;
    logic [IW-1:0]    id_o;
    logic [XL-1:0]    critical_word_o;
    logic             err_o, adp_req_o, adp_type_o, adp_we_o;
    logic [AW-1:0]    adp_addr_o;
    logic [1:0]       adp_size_o;
    logic [IW-1:0]    adp_id_o;
    logic [DW-1:0]    adp_wdata_o;
    logic [DW/8-1:0]  adp_be_o;
    logic             adp_busy_i = 0, adp_gnt_i = 0, adp_valid_i = 0, adp_cw_valid_i = 0;
    logic [DW-1:0]    adp_rdata_i = 0;
    logic [IW-1:0]    adp_id_i = 0;
    logic [XL-1:0]    adp_cw_i = 0;

    int   checks = 0, errors = 0;
    exp_t exp_q[$];

    axi_adapter_arbiter #(.NR_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                          .XLEN(XL), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .type_i(type_i), .we_i(we_i),
        .addr_i(addr_i), .size_i(size_i), .id_i(id_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .valid_o(valid_o), .rdata_o(rdata_o), .id_o(id_o),
        .critical_word_o(critical_word_o), .critical_word_valid_o(critical_word_valid_o),
        .err_o(err_o), .adp_req_o(adp_req_o), .adp_type_o(adp_type_o), .adp_we_o(adp_we_o),
        .adp_addr_o(adp_addr_o), .adp_size_o(adp_size_o), .adp_id_o(adp_id_o),
        .adp_wdata_o(adp_wdata_o), .adp_be_o(adp_be_o), .adp_busy_i(adp_busy_i),
        .adp_gnt_i(adp_gnt_i), .adp_valid_i(adp_valid_i), .adp_rdata_i(adp_rdata_i),
        .adp_id_i(adp_id_i), .adp_cw_i(adp_cw_i), .adp_cw_valid_i(adp_cw_valid_i)
    );

    always #5 clk_i = ~clk_i;

    // Port p presents address 0x1000*(p+1) so the muxed address identifies the owner.
    function automatic logic [AW-1:0] port_addr(input int p);
        return AW'(32'h1000 * (p + 1));
    endfunction

    always @(negedge clk_i) begin
        checks++;
        if ($countones(gnt_o) > 1 || $countones(valid_o) > 1 || $countones(critical_word_valid_o) > 1) begin
            errors++;
            $display("FAIL onehot gnt=%b valid=%b cwv=%b required at most one bit each", gnt_o, valid_o, critical_word_valid_o);
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Scripted adapter: waits for a request, grants it, completes it next cycle, reports observations.
    task automatic run_txn(input logic [DW-1:0] rd, output int port, output logic [NP-1:0] g,
                           output logic [NP-1:0] v, output logic [DW-1:0] r);
        int n = 0;
        while (!adp_req_o && n < 10) begin
            tick;
            n++;
        end
        port = adp_req_o ? int'(adp_addr_o[15:12]) - 1 : -1;
        g = 0; v = 0; r = 0;
        if (!adp_req_o) return;
        adp_gnt_i = 1;
        #1 g = gnt_o;
        tick;
        adp_gnt_i = 0;
        adp_valid_i = 1;
        adp_rdata_i = rd;
        #1 v = valid_o;
        r = rdata_o;
        tick;
        adp_valid_i = 0;
    endtask

    task automatic do_reset;
        rst_i = 1;
        tick;
        tick;
        rst_i = 0;
    endtask

    task automatic test_reset;
        rst_i = 1;
        req_i = 3'b111;
        tick;
        tick;
        checks++;
        if ({gnt_o, valid_o, critical_word_valid_o, adp_req_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b valid=%b cwv=%b req=%b err=%b required all 0", gnt_o, valid_o, critical_word_valid_o, adp_req_o, err_o);
        end
        req_i = 0;
        rst_i = 0;
        tick;
    endtask

    task automatic test_single;
        exp_t e;
        req_i = 3'b001;
        #1;
        checks++;
        if (adp_req_o !== 1'b0) begin errors++; $display("FAIL single_idle_req got %b required 0", adp_req_o); end
        tick;
        checks++;
        if (adp_req_o !== 1'b1 || adp_addr_o !== port_addr(0)) begin
            errors++;
            $display("FAIL single_issue got req=%b addr=%h required 1 %h", adp_req_o, adp_addr_o, port_addr(0));
        end
        checks++;
        if (gnt_o !== 3'b000) begin errors++; $display("FAIL single_no_gnt got %b required 000", gnt_o); end
        adp_gnt_i = 1;
        #1;
        checks++;
        if (gnt_o !== 3'b001) begin errors++; $display("FAIL single_gnt got %b required 001", gnt_o); end
        tick;
        adp_gnt_i = 0;
        req_i = 0;
        checks++;
        if (adp_req_o !== 1'b0) begin errors++; $display("FAIL single_wait_req got %b required 0", adp_req_o); end
        exp_q.push_back('{0, {32{8'hA5}}});
        adp_valid_i = 1;
        adp_rdata_i = {32{8'hA5}};
        #1;
        e = exp_q.pop_front();
        checks++;
        if (valid_o !== NP'(1 << e.port) || rdata_o !== e.rdata) begin
            errors++;
            $display("FAIL single_valid got %b %h required %b %h", valid_o, rdata_o, NP'(1 << e.port), e.rdata);
        end
        tick;
        adp_valid_i = 0;
        req_i = 3'b011;
        tick;
        checks++;
        if (adp_addr_o !== port_addr(1)) begin errors++; $display("FAIL single_rr_ptr got %h required %h", adp_addr_o, port_addr(1)); end
        req_i = 0;
        tick;
    endtask

    task automatic test_round_robin;
        int p;
        logic [NP-1:0] g, v;
        logic [DW-1:0] r;
        exp_t e;
        do_reset;
        req_i = 3'b111;
        for (int i = 0; i < 4; i++) exp_q.push_back('{i % NP, DW'($urandom) << 64 | DW'(i)});
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            run_txn(e.rdata, p, g, v, r);
            checks++;
            if (p !== e.port || g !== NP'(1 << e.port) || v !== NP'(1 << e.port) || r !== e.rdata) begin
                errors++;
                $display("FAIL rr_txn%0d got port=%0d gnt=%b valid=%b required port=%0d", i, p, g, v, e.port);
            end
        end
        req_i = 0;
        tick;
    endtask

    task automatic test_critical_word;
        req_i = 3'b010;
        tick;
        tick;
        adp_gnt_i = 1;
        tick;
        adp_gnt_i = 0;
        req_i = 0;
        adp_cw_valid_i = 1;
        adp_cw_i = 64'h1234;
        #1;
        checks++;
        if (critical_word_valid_o !== 3'b010 || critical_word_o !== 64'h1234) begin
            errors++;
            $display("FAIL critical_word got %b %h required 010 1234", critical_word_valid_o, critical_word_o);
        end
        tick;
        adp_cw_valid_i = 0;
        adp_valid_i = 1;
        #1;
        checks++;
        if (valid_o !== 3'b010) begin errors++; $display("FAIL cw_complete got %b required 010", valid_o); end
        tick;
        adp_valid_i = 0;
    endtask

    task automatic test_withdraw;
        req_i = 3'b100;
        tick;
        tick;
        checks++;
        if (adp_req_o !== 1'b1 || adp_addr_o !== port_addr(2)) begin
            errors++;
            $display("FAIL withdraw_issue got %b %h required 1 %h", adp_req_o, adp_addr_o, port_addr(2));
        end
        req_i = 0;
        #1;
        checks++;
        if (gnt_o !== 3'b000) begin errors++; $display("FAIL withdraw_gnt got %b required 000", gnt_o); end
        tick;
        checks++;
        if (adp_req_o !== 1'b0) begin errors++; $display("FAIL withdraw_idle got %b required 0", adp_req_o); end
        req_i = 3'b111;
        tick;
        checks++;
        if (adp_addr_o !== port_addr(2)) begin errors++; $display("FAIL withdraw_ptr got %h required %h", adp_addr_o, port_addr(2)); end
        req_i = 0;
        adp_busy_i = 1;
        tick;
        tick;
        tick;
        checks++;
        if (adp_req_o !== 1'b1 || adp_addr_o !== port_addr(2)) begin
            errors++;
            $display("FAIL busy_hold got %b %h required 1 %h", adp_req_o, adp_addr_o, port_addr(2));
        end
        adp_gnt_i = 1;
        #1;
        checks++;
        if (gnt_o !== 3'b100) begin errors++; $display("FAIL busy_gnt got %b required 100", gnt_o); end
        tick;
        adp_gnt_i = 0;
        adp_busy_i = 0;
        adp_valid_i = 1;
        #1;
        checks++;
        if (valid_o !== 3'b100) begin errors++; $display("FAIL busy_valid got %b required 100", valid_o); end
        tick;
        adp_valid_i = 0;
    endtask

    task automatic test_watchdog;
        req_i = 3'b001;
        tick;
        tick;
        adp_gnt_i = 1;
        tick;
        adp_gnt_i = 0;
        req_i = 0;
        repeat (7) tick;
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL wd_early got %b required 0", err_o); end
        repeat (13) tick;
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL wd_expire got %b required 1", err_o); end
        adp_valid_i = 1;
        #1;
        checks++;
        if (valid_o !== 3'b001) begin errors++; $display("FAIL wd_complete got %b required 001", valid_o); end
        tick;
        adp_valid_i = 0;
        tick;
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b required 1", err_o); end
        req_i = 3'b010;
        tick;
        tick;
        adp_gnt_i = 1;
        tick;
        adp_gnt_i = 0;
        adp_cw_valid_i = 1;
        adp_valid_i = 1;
        rst_i = 1;
        #1;
        checks++;
        if ({gnt_o, valid_o, critical_word_valid_o, adp_req_o, err_o} !== '0) begin
            errors++;
            $display("FAIL midreset got valid=%b cwv=%b req=%b err=%b required all 0", valid_o, critical_word_valid_o, adp_req_o, err_o);
        end
        tick;
        rst_i = 0;
        adp_cw_valid_i = 0;
        adp_valid_i = 0;
        req_i = 0;
        #1;
        checks++;
        if (adp_req_o !== 1'b0 || err_o !== 1'b0 || valid_o !== 3'b000) begin
            errors++;
            $display("FAIL post_reset got req=%b err=%b valid=%b required 0 0 000", adp_req_o, err_o, valid_o);
        end
    endtask

    task automatic test_issue_valid;
        req_i = 3'b001;
        tick;
        tick;
        adp_valid_i = 1;
        #1;
        checks++;
        if (valid_o !== 3'b000) begin errors++; $display("FAIL issue_valid got %b required 000", valid_o); end
        tick;
        adp_valid_i = 0;
        checks++;
        if (err_o !== 1'b1 || adp_req_o !== 1'b1) begin
            errors++;
            $display("FAIL issue_valid_err got err=%b req=%b required 1 1", err_o, adp_req_o);
        end
        req_i = 0;
        tick;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        do_reset;
        req_i = 3'b011;
        tick;
        adp_gnt_i = 1;
        tick;
        adp_gnt_i = 0;
        req_i = 3'b010;
        exp_q.push_back('{0, {32{8'h3C}}});
        adp_valid_i = 1;
        adp_rdata_i = {32{8'h3C}};
        #1;
        e = exp_q.pop_front();
        checks++;
        if (valid_o !== NP'(1 << e.port) || rdata_o !== e.rdata) begin
            errors++;
            $display("FAIL b2b_valid got %b required %b", valid_o, NP'(1 << e.port));
        end
        tick;
        adp_valid_i = 0;
        checks++;
        if (adp_req_o !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b required 0", adp_req_o); end
        tick;
        checks++;
        if (adp_req_o !== 1'b1 || adp_addr_o !== port_addr(1)) begin
            errors++;
            $display("FAIL b2b_next got %b %h required 1 %h", adp_req_o, adp_addr_o, port_addr(1));
        end
        adp_gnt_i = 1;
        tick;
        adp_gnt_i = 0;
        req_i = 0;
        adp_valid_i = 1;
        #1;
        checks++;
        if (valid_o !== 3'b010) begin errors++; $display("FAIL b2b_done got %b required 010", valid_o); end
        tick;
        adp_valid_i = 0;
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            addr_i[p*AW +: AW] = port_addr(p);
            id_i[p*IW +: IW] = IW'(p + 5);
        end
        test_reset;
        test_single;
        test_round_robin;
        test_critical_word;
        test_withdraw;
        test_watchdog;
        test_issue_valid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
